// File: rtl/map_rom_arbiter_if.sv
// Request/grant/return bundle between the map ROM arbiter, its two requesters
// (VGA renderer, game-logic collision checker) and the single-port map ROM.
interface map_rom_arbiter_if #(
  parameter int ROW_W  = 30,
  parameter int ADDR_W = 5
);
  logic              vga_req;
  logic [ADDR_W-1:0] vga_addr;
  logic              vga_gnt;
  logic              vga_valid;
  logic [ROW_W-1:0]  vga_data;

  logic              gl_req;
  logic [ADDR_W-1:0] gl_addr;
  logic              gl_gnt;
  logic              gl_valid;
  logic [ROW_W-1:0]  gl_data;

  logic              rom_en;
  logic [ADDR_W-1:0] rom_addr;
  logic [ROW_W-1:0]  rom_data;

  logic              err_oob;

  // Arbiter side: accepts requests, owns the ROM address port.
  modport slave (
    input  vga_req, vga_addr, gl_req, gl_addr, rom_data,
    output vga_gnt, vga_valid, vga_data,
    output gl_gnt, gl_valid, gl_data,
    output rom_en, rom_addr, err_oob
  );

  // Environment side: requesters plus the ROM itself.
  modport master (
    output vga_req, vga_addr, gl_req, gl_addr, rom_data,
    input  vga_gnt, vga_valid, vga_data,
    input  gl_gnt, gl_valid, gl_data,
    input  rom_en, rom_addr, err_oob
  );
endinterface

// File: rtl/map_rom_arbiter.sv
// Shares the single-port map ROM between the VGA renderer (priority) and game logic.
// Define MAP_ARB_STARVE_GUARD_EN to bound game-logic wait to STARVE_LIMIT cycles.
module map_rom_arbiter #(
  parameter int ROW_W        = 30,
  parameter int ROWS         = 21,
  parameter int ADDR_W       = 5,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                reset,
  map_rom_arbiter_if.slave    bus
);

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
    $error("map_rom_arbiter: STARVE_LIMIT must be in 1..15");
  end
  if (ROWS > (1 << ADDR_W)) begin : g_bad_rows
    $error("map_rom_arbiter: ADDR_W too narrow for ROWS");
  end

  typedef enum logic {
    OWN_VGA = 1'b0,
    OWN_GL  = 1'b1
  } owner_e;

  // Stage 1: tag travelling alongside the ROM access.
  typedef struct packed {
    logic   valid;
    owner_e owner;
    logic   oob;
  } tag_t;

  // Stage 2: the data has been captured, only the pulse owner remains.
  typedef struct packed {
    logic   valid;
    owner_e owner;
  } ret_t;

  logic              vga_gnt;
  logic              gl_gnt;
  logic              any_gnt;
  logic              force_gl;
  logic [ADDR_W-1:0] sel_addr;
  logic              sel_oob;
  logic              rom_en;

  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  tag_t              tag_q, tag_d;
  ret_t              ret_q, ret_d;
  logic [ROW_W-1:0]  vga_data_q, vga_data_d;
  logic [ROW_W-1:0]  gl_data_q, gl_data_d;
  logic              err_oob_q, err_oob_d;
  logic [ROW_W-1:0]  ret_data;

  // ---------------------------------------------------------------------------
  // Starvation guard
  // ---------------------------------------------------------------------------
`ifdef MAP_ARB_STARVE_GUARD_EN
  logic [3:0] wait_cnt_q, wait_cnt_d;

  always_comb begin
    force_gl = bus.vga_req && bus.gl_req && (wait_cnt_q == 4'(STARVE_LIMIT));
  end

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!bus.gl_req || gl_gnt) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q != 4'hF) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end
`else
  assign force_gl = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Grant and issue (combinational on current requests)
  // ---------------------------------------------------------------------------
  // NOTE: every output of an always_comb gets a default first so no path can
  // leave it unassigned, which would otherwise infer a latch.
  always_comb begin
    vga_gnt = 1'b0;
    gl_gnt  = 1'b0;
    if (reset) begin
      vga_gnt = bus.vga_req && !force_gl;
      gl_gnt  = bus.gl_req && !vga_gnt;
    end
  end

  always_comb begin
    any_gnt    = vga_gnt || gl_gnt;
    sel_addr   = vga_gnt ? bus.vga_addr : bus.gl_addr;
    sel_oob    = (32'(sel_addr) >= ROWS);
    rom_en     = any_gnt && !sel_oob;
    // The ROM address port only moves for a real access; otherwise it parks.
    rom_addr_d = rom_en ? sel_addr : rom_addr_q;
  end

  always_comb begin
    tag_d       = '0;
    tag_d.valid = any_gnt;
    tag_d.owner = gl_gnt ? OWN_GL : OWN_VGA;
    tag_d.oob   = any_gnt && sel_oob;
    err_oob_d   = err_oob_q || (any_gnt && sel_oob);
  end

  // ---------------------------------------------------------------------------
  // Return path: capture ROM data for the stage-1 owner
  // ---------------------------------------------------------------------------
  always_comb begin
    ret_data    = tag_q.oob ? {ROW_W{1'b1}} : bus.rom_data;
    vga_data_d  = vga_data_q;
    gl_data_d   = gl_data_q;
    ret_d       = '0;
    ret_d.valid = tag_q.valid;
    ret_d.owner = tag_q.owner;
    if (tag_q.valid) begin
      if (tag_q.owner == OWN_GL) begin
        gl_data_d = ret_data;
      end else begin
        vga_data_d = ret_data;
      end
    end
  end

  // NOTE: state updates use non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rom_addr_q <= '0;
      tag_q      <= '0;
      ret_q      <= '0;
      vga_data_q <= '0;
      gl_data_q  <= '0;
      err_oob_q  <= 1'b0;
    end else begin
      rom_addr_q <= rom_addr_d;
      tag_q      <= tag_d;
      ret_q      <= ret_d;
      vga_data_q <= vga_data_d;
      gl_data_q  <= gl_data_d;
      err_oob_q  <= err_oob_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.vga_gnt   = vga_gnt;
  assign bus.gl_gnt    = gl_gnt;
  assign bus.rom_en    = rom_en;
  assign bus.rom_addr  = rom_addr_d;
  assign bus.vga_valid = ret_q.valid && (ret_q.owner == OWN_VGA);
  assign bus.gl_valid  = ret_q.valid && (ret_q.owner == OWN_GL);
  assign bus.vga_data  = vga_data_q;
  assign bus.gl_data   = gl_data_q;
  assign bus.err_oob   = err_oob_q;

endmodule

// File: tb/tb_map_rom_arbiter.sv
// Scoreboard bench for map_rom_arbiter: stimulus pushes expected returns,
// a monitor pops and checks them whenever a valid pulse appears.
module tb_map_rom_arbiter;
  localparam int ROW_W        = 30;
  localparam int ROWS         = 21;
  localparam int ADDR_W       = 5;
  localparam int STARVE_LIMIT = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  map_rom_arbiter_if #(.ROW_W(ROW_W), .ADDR_W(ADDR_W)) bus ();

  map_rom_arbiter #(
    .ROW_W(ROW_W), .ROWS(ROWS), .ADDR_W(ADDR_W), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Synchronous ROM model: data one cycle after an enabled address.
  logic [ROW_W-1:0] rom [32];
  always @(posedge clk) begin
    if (bus.rom_en) bus.rom_data <= rom[bus.rom_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    bit               is_gl;
    logic [ROW_W-1:0] data;
    int               cyc;
  } exp_t;
  exp_t sb[$];

  logic [ROW_W-1:0] last_vga = '0;
  logic [ROW_W-1:0] last_gl  = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [ROW_W-1:0] exp_row(input int a);
    return (a >= ROWS) ? {ROW_W{1'b1}} : rom[a];
  endfunction

  task automatic drive(input logic vr, input int va, input logic gr, input int ga);
    @(posedge clk);
    #1;
    bus.vga_req  = vr;
    bus.vga_addr = ADDR_W'(va);
    bus.gl_req   = gr;
    bus.gl_addr  = ADDR_W'(ga);
  endtask

  // One request cycle: check grants at the falling edge, queue the expected return.
  task automatic issue(input logic vr, input int va, input logic gr, input int ga,
                       input logic exp_vg, input logic exp_gg, input string tag);
    exp_t e;
    drive(vr, va, gr, ga);
    @(negedge clk);
    check($sformatf("%s_vga_gnt", tag), 32'(bus.vga_gnt), 32'(exp_vg));
    check($sformatf("%s_gl_gnt", tag), 32'(bus.gl_gnt), 32'(exp_gg));
    if (exp_vg) begin
      e.is_gl = 1'b0; e.data = exp_row(va); e.cyc = cyc;
      sb.push_back(e);
    end
    if (exp_gg) begin
      e.is_gl = 1'b1; e.data = exp_row(ga); e.cyc = cyc;
      sb.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 0, 1'b0, 0);
    @(negedge clk);
  endtask

  task automatic take(input bit is_gl, input logic [ROW_W-1:0] d);
    exp_t e;
    if (sb.size() == 0) begin
      check(is_gl ? "unexpected_gl_valid" : "unexpected_vga_valid", 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    check("ret_owner", 32'(is_gl), 32'(e.is_gl));
    check("ret_data", 32'(d), 32'(e.data));
    check("ret_latency", cyc, e.cyc + 2);
    if (is_gl) begin
      last_gl = e.data;
      check("vga_data_hold", 32'(bus.vga_data), 32'(last_vga));
    end else begin
      last_vga = e.data;
      check("gl_data_hold", 32'(bus.gl_data), 32'(last_gl));
    end
  endtask

  // Monitor: decoupled from stimulus, driven only by valid pulses.
  always @(negedge clk) begin
    if (reset) begin
      if (bus.vga_valid) take(1'b0, bus.vga_data);
      if (bus.gl_valid)  take(1'b1, bus.gl_data);
    end
  end

  task automatic check_reset_values(input string tag);
    check($sformatf("%s_vga_gnt", tag), 32'(bus.vga_gnt), 32'd0);
    check($sformatf("%s_gl_gnt", tag), 32'(bus.gl_gnt), 32'd0);
    check($sformatf("%s_vga_valid", tag), 32'(bus.vga_valid), 32'd0);
    check($sformatf("%s_gl_valid", tag), 32'(bus.gl_valid), 32'd0);
    check($sformatf("%s_rom_en", tag), 32'(bus.rom_en), 32'd0);
    check($sformatf("%s_rom_addr", tag), 32'(bus.rom_addr), 32'd0);
    check($sformatf("%s_vga_data", tag), 32'(bus.vga_data), 32'd0);
    check($sformatf("%s_gl_data", tag), 32'(bus.gl_data), 32'd0);
    check($sformatf("%s_err_oob", tag), 32'(bus.err_oob), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rom[i] = ROW_W'(32'h0ABC_0000 ^ (32'h0011_1111 * i));
    rom[20]      = 30'h2000_0001;
    bus.rom_data = '0;

    // Reset: requests held high must still see no grants.
    reset        = 1'b0;
    bus.vga_req  = 1'b1;
    bus.vga_addr = 5'd1;
    bus.gl_req   = 1'b1;
    bus.gl_addr  = 5'd2;
    repeat (2) @(negedge clk);
    check_reset_values("rst");
    @(posedge clk);
    #1;
    bus.vga_req = 1'b0;
    bus.gl_req  = 1'b0;
    reset       = 1'b1;

    // Single game-logic read of row 20.
    issue(1'b0, 0, 1'b1, 20, 1'b0, 1'b1, "gl20");
    check("gl20_rom_en", 32'(bus.rom_en), 32'd1);
    check("gl20_rom_addr", 32'(bus.rom_addr), 32'd20);
    idle(1);
    check("idle_rom_en", 32'(bus.rom_en), 32'd0);
    check("idle_rom_addr_hold", 32'(bus.rom_addr), 32'd20);
    idle(3);

    // VGA streams rows 0..3 back to back.
    for (int a = 0; a < 4; a++) begin
      issue(1'b1, a, 1'b0, 0, 1'b1, 1'b0, $sformatf("vga_stream%0d", a));
      check($sformatf("vga_stream%0d_rom_addr", a), 32'(bus.rom_addr), 32'(a));
    end
    idle(4);

    // Both requesters held high.
`ifdef MAP_ARB_STARVE_GUARD_EN
    for (int i = 0; i < 6; i++) begin
      issue(1'b1, 3, 1'b1, 7, (i != STARVE_LIMIT), (i == STARVE_LIMIT),
            $sformatf("starve%0d", i));
    end
`else
    for (int i = 0; i < 100; i++) begin
      issue(1'b1, 3, 1'b1, 7, 1'b1, 1'b0, $sformatf("prio%0d", i));
    end
`endif
    idle(4);

    // Out-of-range game-logic row reads back as solid wall.
    issue(1'b0, 0, 1'b1, 25, 1'b0, 1'b1, "oob25");
    check("oob25_rom_en", 32'(bus.rom_en), 32'd0);
    idle(2);
    check("oob_err_set", 32'(bus.err_oob), 32'd1);
    idle(50);
    check("oob_err_sticky", 32'(bus.err_oob), 32'd1);

    // Alternating requesters; data registers hold outside their own pulses.
    issue(1'b1, 2, 1'b0, 0, 1'b1, 1'b0, "alt_vga2");
    issue(1'b0, 0, 1'b1, 7, 1'b0, 1'b1, "alt_gl7");
    idle(4);
    check("alt_vga_data_hold", 32'(bus.vga_data), 32'(rom[2]));
    check("alt_gl_data_hold", 32'(bus.gl_data), 32'(rom[7]));

    // Reset in flight: VGA row 5 granted, reset pulled the next cycle.
    issue(1'b1, 5, 1'b0, 0, 1'b1, 1'b0, "rst_vga5");
    @(posedge clk);
    #1;
    reset = 1'b0;
    sb.delete();
    last_vga = '0;
    last_gl  = '0;
    #1;
    check_reset_values("midrst");
    @(posedge clk);
    @(posedge clk);
    #1;
    bus.vga_req = 1'b0;
    bus.gl_req  = 1'b0;
    reset       = 1'b1;
    idle(6);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
